// File: rtl/arb_req_frontend.sv
// Two-channel request front end: per-channel FIFO plus a request/grant FSM
// that pops one word per grant and flags overflow and grant-wait timeouts.

module arb_req_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_data,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_drop
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_push_ok;
   logic              w_full;

   assign w_full    = (r_count == FULL_CNT);
   assign w_push_ok = i_push && !w_full;
   // A push into a full FIFO is lost even if a pop frees a slot this cycle.
   assign o_drop    = i_push && w_full;

   always_comb begin
      w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(i_pop);
   end

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_next;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = w_full;
endmodule

module arb_req_chan #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 4,
   parameter int WAIT_MAX = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_push_data,
   input  logic                       i_grant,
   input  logic                       i_clr_err,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_request,
   output logic                       o_out_valid,
   output logic [DATA_W-1:0]          o_out_data,
   output logic                       o_ovf,
   output logic                       o_tmo
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int WAIT_W = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [WAIT_W-1:0]   r_wait;
   logic [WAIT_W-1:0]   w_wait_next;
   logic                w_pop;
   logic                w_tmo_set;
   logic                w_drop;
   logic [DATA_W-1:0]   w_head;
   logic [CNT_W-1:0]    w_count;
   logic                r_request;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_ovf;
   logic                r_tmo;

   arb_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_push),
      .i_data  (i_push_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (o_full),
      .o_drop  (w_drop)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The wait counter parks at WAIT_MAX so the timeout fires once per
   // request; a clear while still waiting therefore sticks.
   always_comb begin
      w_state_next = r_state;
      w_wait_next  = r_wait;
      w_pop        = 1'b0;
      w_tmo_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_wait_next = '0;
            if (w_count != '0) begin
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (i_grant) begin
               w_state_next = S_XFER;
               w_pop        = 1'b1;
               w_wait_next  = '0;
            end else if (r_wait != WAIT_SAT) begin
               w_wait_next = r_wait + WAIT_W'(1);
               w_tmo_set   = (r_wait == WAIT_LAST);
            end
         end
         S_XFER: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wait      <= '0;
         r_request   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_ovf       <= 1'b0;
         r_tmo       <= 1'b0;
      end else begin
         r_wait      <= w_wait_next;
         r_request   <= (w_state_next == S_REQ);
         r_out_valid <= w_pop;
         if (w_pop) begin
            r_out_data <= w_head;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (i_clr_err) begin
            r_ovf <= 1'b0;
         end
         if (w_tmo_set) begin
            r_tmo <= 1'b1;
         end else if (i_clr_err) begin
            r_tmo <= 1'b0;
         end
      end
   end

   assign o_count     = w_count;
   assign o_request   = r_request;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_ovf       = r_ovf;
   assign o_tmo       = r_tmo;
endmodule

module arb_req_frontend #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 4,
   parameter int WAIT_MAX = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [1:0]                 i_push,
   input  logic [DATA_W-1:0]          i_push_data0,
   input  logic [DATA_W-1:0]          i_push_data1,
   output logic [1:0]                 o_full,
   output logic [$clog2(DEPTH):0]     o_count0,
   output logic [$clog2(DEPTH):0]     o_count1,
   output logic [1:0]                 o_request,
   input  logic [1:0]                 i_grant,
   output logic [1:0]                 o_out_valid,
   output logic [DATA_W-1:0]          o_out_data0,
   output logic [DATA_W-1:0]          o_out_data1,
   output logic [1:0]                 o_ovf,
   output logic [1:0]                 o_tmo,
   input  logic                       i_clr_err
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [1:0][DATA_W-1:0] w_push_data;
   logic [1:0][DATA_W-1:0] w_out_data;
   logic [1:0][CNT_W-1:0]  w_count;

   assign w_push_data[0] = i_push_data0;
   assign w_push_data[1] = i_push_data1;

   // Channels share nothing but the clock, reset and error clear.
   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      arb_req_chan #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .WAIT_MAX (WAIT_MAX)
      ) u_chan (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_push      (i_push[gi]),
         .i_push_data (w_push_data[gi]),
         .i_grant     (i_grant[gi]),
         .i_clr_err   (i_clr_err),
         .o_full      (o_full[gi]),
         .o_count     (w_count[gi]),
         .o_request   (o_request[gi]),
         .o_out_valid (o_out_valid[gi]),
         .o_out_data  (w_out_data[gi]),
         .o_ovf       (o_ovf[gi]),
         .o_tmo       (o_tmo[gi])
      );
   end

   assign o_count0    = w_count[0];
   assign o_count1    = w_count[1];
   assign o_out_data0 = w_out_data[0];
   assign o_out_data1 = w_out_data[1];
endmodule
